// File: rtl/fp32_max.sv
// Registered two-input IEEE-754 binary32 maximum with signed-zero, subnormal and NaN handling.
// Define FP32_MAX_NAN_PROP_EN to propagate any NaN input as the canonical quiet NaN instead of maxNum.
module fp32_max #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  localparam int unsigned DATA_WIDTH = 1 + EXP_W + MAN_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_A,
  input  logic [DATA_WIDTH-1:0] in_B,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  out_sel
);

  localparam int unsigned MAG_W = EXP_W + MAN_W;
  localparam logic [DATA_WIDTH-1:0] CANON_NAN =
    {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic                  w_a_sign;
  logic                  w_b_sign;
  logic [MAG_W-1:0]      w_a_mag;
  logic [MAG_W-1:0]      w_b_mag;
  logic                  w_a_nan;
  logic                  w_b_nan;
  logic                  w_b_wins;
  logic                  w_gen_nan;
  logic [DATA_WIDTH-1:0] w_max;
  logic                  w_sel;

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_out;
  logic                  r_sel;

  assign w_a_sign = in_A[DATA_WIDTH-1];
  assign w_b_sign = in_B[DATA_WIDTH-1];
  assign w_a_mag  = in_A[MAG_W-1:0];
  assign w_b_mag  = in_B[MAG_W-1:0];
  assign w_a_nan  = (&in_A[MAG_W-1:MAN_W]) && (|in_A[MAN_W-1:0]);
  assign w_b_nan  = (&in_B[MAG_W-1:MAN_W]) && (|in_B[MAN_W-1:0]);

  // Ordered compare on sign-magnitude encoding; ties keep A, so -0/+0 resolves by sign alone.
  always_comb begin
    w_b_wins = 1'b0;
    if (w_a_sign != w_b_sign) begin
      w_b_wins = w_a_sign;
    end else if (!w_a_sign) begin
      w_b_wins = (w_b_mag > w_a_mag);
    end else begin
      w_b_wins = (w_b_mag < w_a_mag);
    end
  end

  // NaN override of the ordered result.
  always_comb begin
    w_gen_nan = 1'b0;
    w_sel     = w_b_wins;
`ifdef FP32_MAX_NAN_PROP_EN
    if (w_a_nan || w_b_nan) begin
      w_gen_nan = 1'b1;
      w_sel     = 1'b0;
    end
`else
    if (w_a_nan && w_b_nan) begin
      w_gen_nan = 1'b1;
      w_sel     = 1'b0;
    end else if (w_a_nan) begin
      w_sel = 1'b1;
    end else if (w_b_nan) begin
      w_sel = 1'b0;
    end
`endif
    if (w_gen_nan) begin
      w_max = CANON_NAN;
    end else if (w_sel) begin
      w_max = in_B;
    end else begin
      w_max = in_A;
    end
  end

  // Result register; idle cycles hold the last result and drop valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_out   <= '0;
      r_sel   <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_out <= w_max;
        r_sel <= w_sel;
      end
    end
  end

  assign out_valid = r_valid;
  assign out       = r_out;
  assign out_sel   = r_sel;

endmodule

// File: tb/tb_fp32_max.sv
// Directed self-checking bench for fp32_max; NaN expectations follow FP32_MAX_NAN_PROP_EN.
module tb_fp32_max;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_A;
  logic [31:0] in_B;
  logic        out_valid;
  logic [31:0] out;
  logic        out_sel;

  int n_vec = 0;
  int n_err = 0;

  fp32_max dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_A      (in_A),
    .in_B      (in_B),
    .out_valid (out_valid),
    .out       (out),
    .out_sel   (out_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_out,
                         input logic e_sel, input logic e_vld);
    chk({tag, ".out"}, out, e_out);
    chk({tag, ".sel"}, 32'(out_sel), 32'(e_sel));
    chk({tag, ".vld"}, 32'(out_valid), 32'(e_vld));
  endtask

  // Present a pair for one edge, then check the registered result just after that edge.
  task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] e_out, input logic e_sel);
    @(negedge clk);
    in_A     = a;
    in_B     = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk_all(tag, e_out, e_sel, 1'b1);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_A     = 32'h4049_0FDB;
    in_B     = 32'h4000_0000;

    // Reset held with live operands.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_all("reset", 32'h0000_0000, 1'b0, 1'b0);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;

    // Mixed signs and magnitudes, back-to-back.
    step("pos_pos",   32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 1'b1);
    step("neg_neg",   32'hC000_0000, 32'hBF80_0000, 32'hBF80_0000, 1'b1);
    step("pos_neg",   32'h3F80_0000, 32'hC2C8_0000, 32'h3F80_0000, 1'b0);
    step("neg_neg_a", 32'hBF80_0000, 32'hBF80_0001, 32'hBF80_0000, 1'b0);

    // Zeros and equality.
    step("mz_pz",     32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1);
    step("pz_mz",     32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0);
    step("mz_mz",     32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0);
    step("equal",     32'h4120_0000, 32'h4120_0000, 32'h4120_0000, 1'b0);

    // Extremes.
    step("subn_zero", 32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 1'b0);
    step("nsubn_mz",  32'h8000_0001, 32'h8000_0000, 32'h8000_0000, 1'b1);
    step("ninf_max",  32'hFF80_0000, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b1);
    step("pinf_max",  32'h7F80_0000, 32'h7F7F_FFFF, 32'h7F80_0000, 1'b0);

    // NaN handling.
`ifdef FP32_MAX_NAN_PROP_EN
    step("qnan_a",    32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 1'b0);
    step("nan_b",     32'h3F80_0000, 32'hFF80_0001, 32'h7FC0_0000, 1'b0);
`else
    step("qnan_a",    32'h7FC0_0001, 32'h3F80_0000, 32'h3F80_0000, 1'b1);
    step("nan_b",     32'hBF80_0000, 32'hFF80_0001, 32'hBF80_0000, 1'b0);
`endif
    step("nan_nan",   32'h7F80_0001, 32'hFFC0_0000, 32'h7FC0_0000, 1'b0);

    // Valid gating: result holds while idle operands change.
    step("gate_pair", 32'h4080_0000, 32'hC080_0000, 32'h4080_0000, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_A     = 32'h3F80_0000 + 32'(i);
      in_B     = 32'h7F80_0000;
      @(posedge clk);
      #1;
      chk_all("gate_idle", 32'h4080_0000, 1'b0, 1'b0);
    end

    // Asynchronous reset between edges.
    step("pre_rst",   32'h0000_0000, 32'h4120_0000, 32'h4120_0000, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 32'h0000_0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst",  32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
